// File: rtl/outnum_fmt_pkg.sv
// outnum_fmt_pkg: shared FSM encoding, ASCII constants and digit-to-character helper
//   st_idle..st_emit_d2 : formatter states
//   ZERO / MINUS / HEXA_OFS : ASCII bases for '0', '-', and 'A'-10
//   digit_char(d)       : 0..9 -> '0'..'9', 10..15 -> 'A'..'F'
package outnum_fmt_pkg;

    typedef enum logic [2:0] {
        st_idle,
        st_conv,
        st_emit_sign,
        st_emit_pad,
        st_emit_dig,
        st_emit_d1,
        st_emit_d2
    } state_t;

    localparam logic [7:0] ZERO     = 8'h30;
    localparam logic [7:0] MINUS    = 8'h2D;
    localparam logic [7:0] HEXA_OFS = 8'h37;

    // Decimal digits never exceed 9, so one mapping serves both radices.
    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return (d > 4'd9) ? HEXA_OFS + {4'd0, d} : ZERO + {4'd0, d};
    endfunction

endpackage

// File: rtl/outnum_fmt_divmod10_seq.sv
// divmod10_seq: sequential restoring divide-by-10, fixed latency NBITS+1 cycles
//   clk, rst_n    : clock, async active-low reset
//   start         : load dividend and begin (restarts a division in progress)
//   dividend      : NBITS-bit unsigned input
//   quotient      : dividend / 10, valid while result_ready
//   remainder     : dividend % 10, valid while result_ready
//   result_ready  : idle and not being started
module divmod10_seq #(
    parameter int NBITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NBITS-1:0] dividend,
    output logic [NBITS-1:0] quotient,
    output logic [3:0]       remainder,
    output logic             result_ready
);

    localparam int CW = $clog2(NBITS + 1);

    logic [NBITS-1:0] r_q;
    logic [3:0]       r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic [4:0]       w_t;
    logic             w_ge;

    // Dividend bits shift out of the top of r_q while quotient bits shift in at the bottom.
    assign w_t  = {r_rem, r_q[NBITS-1]};
    assign w_ge = w_t >= 5'd10;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_q    <= dividend;
            r_rem  <= '0;
            r_cnt  <= CW'(NBITS);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_q    <= {r_q[NBITS-2:0], w_ge};
            r_rem  <= w_ge ? 4'(w_t - 5'd10) : w_t[3:0];
            r_cnt  <= r_cnt - CW'(1);
            r_busy <= r_cnt != CW'(1);
        end
    end

    assign quotient     = r_q;
    assign remainder    = r_rem;
    assign result_ready = ~r_busy & ~start;

endmodule

// File: rtl/outnum_fmt.sv
// outnum_fmt: formats an NBITS value as decimal/hex ASCII (sign, zero pad, two delimiters)
//             and streams it out byte by byte over valid/ready
//   clk, rst_n                 : clock, async active-low reset
//   start                      : latch inputs and begin a job (aborts any job in flight)
//   n, hex_mode, signed_mode   : value and its interpretation
//   minwidth                   : zero-padded minimum digit count (clamped to MAXDIGITS)
//   delim1byte, delim2byte     : trailing bytes, 0 = omit
//   out_byte/out_valid/out_ready : byte stream
//   result                     : bytes emitted by the last completed job
//   result_ready               : idle and not being started
module outnum_fmt
    import outnum_fmt_pkg::*;
#(
    parameter int NBITS     = 16,
    parameter int MAXDIGITS = 5,
    parameter int CNTW      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NBITS-1:0] n,
    input  logic             hex_mode,
    input  logic             signed_mode,
    input  logic [3:0]       minwidth,
    input  logic [7:0]       delim1byte,
    input  logic [7:0]       delim2byte,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNTW-1:0]  result,
    output logic             result_ready
);

    localparam int NDW = $clog2(MAXDIGITS + 1);

    state_t           r_state, w_next, w_tail;
    logic             r_hex, r_neg, r_wait;
    logic [NBITS-1:0] r_mag;
    logic [3:0]       r_minw;
    logic [7:0]       r_d1, r_d2;
    logic [3:0]       r_stk [2**NDW];
    logic [NDW-1:0]   r_nd;
    logic [CNTW-1:0]  r_pad, r_cnt, r_result;

    logic             w_in_neg;
    logic [NBITS-1:0] w_quo, w_qnext;
    logic [3:0]       w_rem, w_dig;
    logic [NDW-1:0]   w_top;
    logic [CNTW-1:0]  w_minw, w_nd1, w_pad_new;
    logic             w_div_start, w_div_rdy, w_push, w_conv_done, w_acc, w_fin;

    divmod10_seq #(.NBITS(NBITS)) u_div (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (w_div_start),
        .dividend     (r_mag),
        .quotient     (w_quo),
        .remainder    (w_rem),
        .result_ready (w_div_rdy)
    );

    assign w_in_neg    = signed_mode & n[NBITS-1];
    // r_wait marks a division in flight; a digit is collected once the divider reports ready.
    assign w_div_start = (r_state == st_conv) & ~r_hex & ~r_wait & ~start;
    assign w_push      = (r_state == st_conv) & ~start & (r_hex | (r_wait & w_div_rdy));
    assign w_dig       = r_hex ? r_mag[3:0] : w_rem;
    assign w_qnext     = r_hex ? r_mag >> 4 : w_quo;
    assign w_conv_done = w_push & (w_qnext == '0);
    assign w_acc       = out_valid & out_ready;
    assign w_top       = r_nd - NDW'(1);
    assign w_minw      = (int'(r_minw) > MAXDIGITS) ? CNTW'(MAXDIGITS) : CNTW'(r_minw);
    // Digit count including the digit pushed this cycle.
    assign w_nd1       = CNTW'(r_nd) + CNTW'(1);
    assign w_pad_new   = (w_minw > w_nd1) ? w_minw - w_nd1 : '0;
    assign w_tail      = (r_d1 != '0) ? st_emit_d1 : ((r_d2 != '0) ? st_emit_d2 : st_idle);
    assign w_fin       = w_acc & ~start & (w_next == st_idle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= st_idle;
        else        r_state <= w_next;
    end

    // Empty emit states are bypassed here so no idle cycle appears between bytes.
    always_comb begin
        w_next = r_state;
        if (start) w_next = st_conv;
        else begin
            case (r_state)
                st_conv:      if (w_conv_done) w_next = r_neg ? st_emit_sign : ((w_pad_new != '0) ? st_emit_pad : st_emit_dig);
                st_emit_sign: if (w_acc) w_next = (r_pad != '0) ? st_emit_pad : st_emit_dig;
                st_emit_pad:  if (w_acc && r_pad == CNTW'(1)) w_next = st_emit_dig;
                st_emit_dig:  if (w_acc && r_nd == NDW'(1)) w_next = w_tail;
                st_emit_d1:   if (w_acc) w_next = (r_d2 != '0) ? st_emit_d2 : st_idle;
                st_emit_d2:   if (w_acc) w_next = st_idle;
                default:      w_next = r_state;
            endcase
        end
    end

    always_comb begin
        out_valid    = r_state inside {st_emit_sign, st_emit_pad, st_emit_dig, st_emit_d1, st_emit_d2};
        out_byte     = (r_state == st_emit_sign) ? MINUS :
                       (r_state == st_emit_pad)  ? ZERO :
                       (r_state == st_emit_dig)  ? digit_char(r_stk[w_top]) :
                       (r_state == st_emit_d1)   ? r_d1 :
                       (r_state == st_emit_d2)   ? r_d2 : 8'h00;
        result_ready = (r_state == st_idle) & ~start;
        result       = r_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex    <= 1'b0;
            r_neg    <= 1'b0;
            r_wait   <= 1'b0;
            r_mag    <= '0;
            r_minw   <= '0;
            r_d1     <= '0;
            r_d2     <= '0;
            r_stk    <= '{default: '0};
            r_nd     <= '0;
            r_pad    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (start) begin
            r_hex  <= hex_mode;
            r_neg  <= w_in_neg;
            r_mag  <= w_in_neg ? ~n + NBITS'(1) : n;
            r_minw <= minwidth;
            r_d1   <= delim1byte;
            r_d2   <= delim2byte;
            r_wait <= 1'b0;
            r_nd   <= '0;
            r_pad  <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_div_start) r_wait <= 1'b1;
            if (w_push) begin
                r_stk[r_nd] <= w_dig;
                r_nd        <= r_nd + NDW'(1);
                r_mag       <= w_qnext;
                r_wait      <= 1'b0;
                if (w_conv_done) r_pad <= w_pad_new;
            end
            if (w_acc) begin
                r_cnt <= r_cnt + CNTW'(1);
                if (r_state == st_emit_pad) r_pad <= r_pad - CNTW'(1);
                if (r_state == st_emit_dig) r_nd <= r_nd - NDW'(1);
            end
            if (w_fin) r_result <= r_cnt + CNTW'(1);
        end
    end

endmodule

// File: doc/outnum_fmt.md
Name: outnum_fmt

Overview:
- Parametrised number-to-ASCII formatter: converts an NBITS value to decimal or hex digits, optionally signed and zero-padded, then appends up to two delimiter bytes.
- Streams the characters out as bytes over a valid/ready handshake to a UART byte sender or FIFO, instead of driving a fixed 12-char output routine.
- Successor of the 16-bit, 2-postdelim decimal output routine in the simple-I/O library.

Parameters:
- NBITS, 16, width of input value n (4..32).
- MAXDIGITS, 5, digit buffer depth; must be >= decimal digits of 2^NBITS-1 (5 for 16, 10 for 32).
- CNTW, 5, width of result (byte count); must hold MAXDIGITS+3.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches all inputs, begins a job
- n  in  NBITS  value to print
- hex_mode  in  1  0 = decimal, 1 = hex (uppercase A-F)
- signed_mode  in  1  1 = n is two's complement
- minwidth  in  4  minimum digit count, zero-padded; values above MAXDIGITS clamp to MAXDIGITS
- delim1byte  in  8  first trailing byte; 8'd0 = omit
- delim2byte  in  8  second trailing byte; 8'd0 = omit
- out_byte  out  8  character being offered
- out_valid  out  1  out_byte is valid
- out_ready  in  1  sink accepts the byte when out_valid & out_ready
- result  out  CNTW  number of bytes emitted by the last job
- result_ready  out  1  idle/done, same semantics as the codebase's result_ready

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, out_valid=0, out_byte=0, result=0, digit count=0.
  - result_ready=1 once reset is released.
- result_ready = (state==IDLE) & ~start.
- States: IDLE -> CONV -> EMIT_SIGN -> EMIT_PAD -> EMIT_DIG -> EMIT_D1 -> EMIT_D2 -> IDLE.
- Start:
  - start in any state, including mid-job, latches the inputs and enters CONV next cycle.
  - out_valid drops that same next cycle; the aborted byte is not counted.
  - start has priority over every other transition.
- CONV, signed input:
  - If signed_mode & n[NBITS-1], set neg=1 and magnitude = -n, computed in NBITS+1 bits.
  - Most-negative value prints correctly, e.g. -32768 for NBITS=16.
- CONV, hex: one digit per cycle from the low nibble, shifting magnitude right by 4. Stop when magnitude==0 and at least one digit is produced.
- CONV, decimal:
  - One digit per divmod10 sub-module run, NBITS+1 cycles per digit.
  - Remainder becomes the digit and quotient becomes the new magnitude; same stop rule.
- Digits are pushed into a MAXDIGITS-deep LIFO. Value 0 yields a single '0'.
- Emission:
  - Each EMIT state holds out_valid=1 with a stable out_byte until out_valid & out_ready, then advances.
  - Each emitted byte increments the count.
- EMIT_SIGN: '-' (8'h2D) only if neg, else skipped with zero cycles of out_valid.
- EMIT_PAD: emits '0' (8'h30) for max(0, clamp(minwidth) - ndigits) bytes.
- EMIT_DIG: pops the LIFO, most significant digit first. Decimal = 8'h30+d; hex d>9 = 8'h37+d.
- EMIT_D1 and EMIT_D2: emit delim1byte / delim2byte when nonzero, else skipped.
- Job end: on the accept of the final byte, result <= count and state <= IDLE. out_valid is low the following cycle.
- out_ready held low: the block stalls indefinitely with out_byte stable; no timeout.
- out_ready tied high: one byte per cycle, with no bubble between emit states.
- Register stepping: any skipped-state evaluation costs at most one cycle with out_valid=0 between bytes.
- Latency, hex: 1 + ndigits cycles of CONV before the first byte.
- Latency, decimal: about ndigits*(NBITS+1) cycles of CONV before the first byte.

Decomposition:
- Shared package:
  - State encoding constants (st_idle .. st_emit_d2).
  - ASCII constants: ZERO=8'h30, MINUS=8'h2D, HEXA_OFS=8'h37.
- One sub-module: divmod10_seq (NBITS param).
  - Restoring shift-subtract divider by constant 10.
  - Ports: clk, rst_n, start, dividend, quotient, remainder[3:0], result_ready.
  - Fixed latency NBITS+1 cycles.

Test Plan:
- Decimal, unsigned: n=1234, delims 8'h0D,8'h0A, out_ready=1 -> bytes 31 32 33 34 0D 0A, result=6, result_ready high after the last accept.
- Signed boundary: NBITS=16, signed_mode=1, n=16'h8000, delims 0,0 -> 2D 33 32 37 36 38 ("-32768"), result=6. Also n=0 -> single 30, result=1.
- Hex with padding: hex_mode=1, n=16'h00AF, minwidth=4, delim1=8'h20, delim2=0 -> 30 30 41 46 20, result=5. minwidth=15 clamps to 5 -> 30 30 30 41 46 20.
- Backpressure: n=65535, out_ready toggled with random stalls -> out_byte never changes while out_valid & ~out_ready, sequence is 36 35 35 33 35, result=5.
- Abort and reset:
  - Pulse start with n=99 during EMIT_DIG of a prior job -> out_valid low the next cycle, then 39 39 only, result=2.
  - Assert rst_n=0 mid-CONV -> out_valid=0 immediately and result_ready=1 after release.
